// File: rtl/bin_to_bcd16_pkg.sv
// Shared widths and FSM state type for the 16-bit binary to 5-digit BCD converter.
package bin_to_bcd16_pkg;

    localparam int unsigned BIN_W  = 16;
    localparam int unsigned DIGITS = 5;
    localparam int unsigned ITERS  = 16;
    localparam int unsigned BCD_W  = DIGITS * 4;
    localparam int unsigned CNT_W  = 5;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin_to_bcd16_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added before the shift.
module bcd_digit_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin_to_bcd16.sv
// Sequential 16-bit binary to packed 5-digit BCD converter, one input bit per clock.
module bin_to_bcd16
    import bin_to_bcd16_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [BIN_W-1:0]     bin_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [BCD_W-1:0]     bcd_o
);

    state_t                   state_q, state_d;
    logic [BIN_W-1:0]         sr_q, sr_d;
    logic [BCD_W-1:0]         work_q, work_d;
    logic [BCD_W-1:0]         bcd_q, bcd_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BCD_W-1:0]         adj;
    logic [BCD_W+BIN_W-1:0]   shifted;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_digit_add3 u_add3 (
            .digit_i (work_q[4*g +: 4]),
            .digit_o (adj[4*g +: 4])
        );
    end

    assign shifted = {adj, sr_q} << 1;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        work_d  = work_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sr_d    = bin_i;
                    work_d  = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {work_d, sr_d} = shifted;
                cnt_d          = cnt_q + 1'b1;
                // Result is published from the final shift so DONE needs no extra stage.
                if (cnt_q == LAST_ITER) begin
                    bcd_d   = shifted[BCD_W+BIN_W-1 -: BCD_W];
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            work_q  <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            work_q  <= work_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o = (state_q == S_SHIFT);
    assign done_o = (state_q == S_DONE);
    assign bcd_o  = bcd_q;

endmodule

// File: doc/bin_to_bcd16.md
BIN_TO_BCD16 -- requirements
Module: bin_to_bcd16

Interface
REQ-001 Parameters: none; widths fixed by shared package constants (BIN_W = 16, DIGITS = 5).
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request to convert Bin; sampled on rising Clk edges.
REQ-005 Bin  input  16  unsigned binary value, e.g. the LFSR register Q; sampled only when Start is accepted.
REQ-006 Busy  output  1  high while a conversion is in progress.
REQ-007 Done  output  1  single-cycle pulse when BCD is updated.
REQ-008 BCD  output  20  five packed BCD digits; [19:16] is ten-thousands, [3:0] is units.

Function
REQ-009 Algorithm: sequential shift-add-3 (double dabble); one input bit per Clk cycle.
REQ-010 FSM states are IDLE, SHIFT and DONE; the encoding is defined in the package.
REQ-011 In IDLE with Start=1:
- Bin is captured into a 16-bit shift register.
- A 20-bit working BCD register is cleared.
- The 5-bit iteration counter is set to 0.
- The FSM moves to SHIFT and Busy goes high on the next cycle.
REQ-012 Each SHIFT cycle:
- First, every working digit >= 5 has 3 added; digits <= 4 are unchanged.
- Then {working BCD, shift register} is shifted left by 1, bringing in the shift register MSB.
- The counter increments.
REQ-013 After the 16th SHIFT cycle (counter == 15), the FSM goes to DONE and the working value is copied to BCD.
REQ-014 DONE lasts exactly one cycle: Done=1 and Busy=0; the FSM then returns to IDLE.
REQ-015 Latency: Start is accepted at edge N and Done is high during cycle N+17 (1 capture cycle + 16 shift cycles).
REQ-016 Start in SHIFT or DONE is ignored: it is neither queued nor does it restart the conversion.
REQ-017 The earliest next accepted Start is the edge after the DONE cycle, giving a back-to-back throughput of one conversion per 18 cycles.
REQ-018 BCD holds the last completed result until the next DONE; it does not change during SHIFT.
REQ-019 Bin changing after acceptance has no effect on the result in progress.
REQ-020 Every output digit is in the range 0..9 for all inputs 0..65535; the maximum BCD is 0x65535.
REQ-021 No overflow case exists (5 digits cover 16 bits), so no error output is provided.

Reset
REQ-022 Reset=1 forces the following immediately, independent of Clk:
- FSM to IDLE.
- Busy=0, Done=0, BCD=20'h00000.
- Counter and working registers cleared.
REQ-023 Reset mid-conversion aborts the conversion: no Done pulse follows and BCD reads 0.
REQ-024 Start is ignored while Reset=1; the first accepted Start is on the first rising edge with Reset=0.

Structure
REQ-025 The shared package holds BIN_W, DIGITS, ITERS (16) and the FSM state type/encoding.
REQ-026 A single combinational sub-module, bcd_digit_add3 (4-bit in, 4-bit out: +3 if >= 5), is instantiated DIGITS times.
REQ-027 All sequential logic lives in bin_to_bcd16 in one clocked process with asynchronous reset.
REQ-028 The block sits between the LFSR generator and the hex_7seg digit decoders, and shall drive them directly from BCD nibbles.

Verification
REQ-029 Bin=16'h8000 (LFSR seed), Start pulse -> Done at cycle N+17 with BCD=20'h32768; Busy high for cycles N+1..N+16.
REQ-030 Bin=16'hFFFF -> BCD=20'h65535; Bin=16'h0000 -> BCD=20'h00000 with a Done pulse still produced.
REQ-031 Start held high continuously with Bin=16'd1234 -> one Done per 18 cycles, each with BCD=20'h01234; no Done is missed or duplicated.
REQ-032 Start with Bin=16'd999, then Start with Bin=16'd42 at cycle N+5 -> the second Start is ignored; Done at N+17 with BCD=20'h00999.
REQ-033 Reset asserted at cycle N+8 of a conversion of 16'd50000 -> Busy, Done and BCD go to 0 asynchronously, and no Done appears afterwards.
REQ-034 A random sweep of 1000 values compared against a reference decimal model -> zero mismatches, and every nibble <= 9.
